uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 77 +++++++
 rtl/uart_tx_buf.sv | 147 ++++++++++++++
 tb/tb_uart_tx_buf.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART transmitter constants and TX state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DELAY_FRAMES_DEFAULT = 234;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Brief    : Single-clock byte FIFO with occupancy count; pointers wrap mod DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int COUNT_W = AW + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == COUNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buf
// Brief    : Buffered 8N1 UART transmitter: byte FIFO feeding a framing FSM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int               CNT_W     = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE  = TX_IDLE;
    localparam logic [2:0] ST_START = TX_START;
    localparam logic [2:0] ST_DATA  = TX_DATA;
    localparam logic [2:0] ST_STOP  = TX_STOP;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             bit_done;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign uart_tx  = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign bit_done = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_rd_data;
                    tx_d       = 1'b0;
                    baud_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // Present the next bit as the current one is shifted out.
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buf
// Brief    : Scoreboard bench for uart_tx_buf; line decoded against 8N1 frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buf;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int FL    = 10 * D;
    localparam int DD    = 234;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [7:0]    in_data    = 8'h00;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    logic [7:0]    in_data_d  = 8'h00;
    logic          in_valid_d = 1'b0;
    logic          in_ready_d;
    logic          uart_tx_d;
    logic          busy_d;
    logic [2:0]    fifo_count_d;

    int            n_cmp    = 0;
    int            n_err    = 0;
    int            cyc      = 0;
    int            busy_cyc = 0;
    int            peak     = 0;
    logic [7:0]    exp_q [$];

    uart_tx_buf #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_buf u_dut_def (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data_d),
        .in_valid   (in_valid_d),
        .in_ready   (in_ready_d),
        .uart_tx    (uart_tx_d),
        .busy       (busy_d),
        .fifo_count (fifo_count_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal 8N1 line: start 0, data LSB first, stop 1, each symbol lasting D cycles.
    function automatic logic [FL-1:0] frame_wave(input logic [7:0] b);
        logic [9:0]    sym;
        logic [FL-1:0] w;
        sym = {1'b1, b, 1'b0};
        for (int i = 0; i < FL; i++) w[i] = sym[i / D];
        return w;
    endfunction

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : accept_sampler
        forever begin
            @(posedge clk);
            if (reset_n && in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    initial begin : monitor
        logic          active;
        int            idx;
        logic [FL-1:0] got;
        logic [FL-1:0] want;
        logic          busy_ok;
        active = 1'b0;
        idx = 0;
        got = '0;
        want = '0;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = 1'b0;
                exp_q.delete();
            end else begin
                if (busy) busy_cyc++;
                if (int'(fifo_count) > peak) peak = int'(fifo_count);
                if (!active && uart_tx == 1'b0) begin
                    active  = 1'b1;
                    idx     = 0;
                    busy_ok = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got a start bit, expected no frame (t=%0t)", $time);
                        want = frame_wave(8'h00);
                    end else begin
                        want = frame_wave(exp_q.pop_front());
                    end
                end
                if (active) begin
                    got[idx] = uart_tx;
                    if (!busy) busy_ok = 1'b0;
                    if (idx == FL - 1) begin
                        check("frame_wave", 64'(got), 64'(want));
                        check("frame_busy", 64'(busy_ok), 64'(1));
                        active = 1'b0;
                    end else begin
                        idx++;
                    end
                end
            end
        end
    end

    task automatic wait_idle(output int at);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b, expected 0 within 20000 cycles", busy);
        end
        at = cyc;
    endtask

    task automatic push_one(input logic [7:0] b);
        int guard;
        guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: in_ready=%0b, expected 1 within 5000 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : main
        int         ca;
        int         tend;
        int         quiet;
        int         mism;
        int         start_len;
        logic       in_start;
        logic [9:0] sym_d;
        logic [7:0] burst [4];
        logic [7:0] def_byte;

        burst = '{8'h55, 8'hAA, 8'h0F, 8'hF0};

        // Reset state while reset_n is held low.
        repeat (3) @(negedge clk);
        check("rst_uart_tx",  64'(uart_tx),    64'(1));
        check("rst_busy",     64'(busy),       64'(0));
        check("rst_count",    64'(fifo_count), 64'(0));
        check("rst_in_ready", 64'(in_ready),   64'(1));
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x4C: line drops one edge after acceptance, frame is 40 cycles.
        busy_cyc = 0;
        in_data  = 8'h4C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ca = cyc;
        check("lat_pre_tx",    64'(uart_tx),    64'(1));
        check("lat_pre_count", 64'(fifo_count), 64'(1));
        @(negedge clk);
        check("lat_tx_low",    64'(uart_tx),    64'(0));
        check("lat_busy",      64'(busy),       64'(1));
        check("lat_count",     64'(fifo_count), 64'(0));
        wait_idle(tend);
        check("single_span",   64'(tend - ca),  64'(FL + 1));
        check("single_busy",   64'(busy_cyc),   64'(FL));
        repeat (5) @(negedge clk);

        // Back-to-back burst of four: contiguous frames, peak occupancy 3.
        busy_cyc = 0;
        peak     = 0;
        for (int i = 0; i < 4; i++) begin
            in_data  = burst[i];
            in_valid = 1'b1;
            @(negedge clk);
            if (i == 0) ca = cyc;
        end
        in_valid = 1'b0;
        wait_idle(tend);
        check("burst_span", 64'(tend - ca), 64'(4 * FL + 1));
        check("burst_busy", 64'(busy_cyc),  64'(4 * FL));
        check("burst_peak", 64'(peak),      64'(3));
        repeat (5) @(negedge clk);

        // Full: four bytes behind a frame in flight, a fifth is held off.
        push_one(8'h3C);
        for (int i = 0; i < 4; i++) begin
            in_data  = 8'hA1 + 8'(i * 17);
            in_valid = 1'b1;
            @(negedge clk);
        end
        check("full_count", 64'(fifo_count), 64'(DEPTH));
        check("full_ready", 64'(in_ready),   64'(0));
        in_data = 8'hE5;
        repeat (8) @(negedge clk);
        check("full_hold_count", 64'(fifo_count), 64'(DEPTH));
        check("full_hold_ready", 64'(in_ready),   64'(0));
        in_valid = 1'b0;
        wait_idle(tend);
        repeat (5) @(negedge clk);

        // Push on the very edge where STOP hands over to the next START with count 2.
        for (int i = 0; i < 3; i++) begin
            in_data  = 8'h12 + 8'(i * 34);
            in_valid = 1'b1;
            @(negedge clk);
            if (i == 0) ca = cyc;
        end
        in_valid = 1'b0;
        while (cyc < ca + FL) @(negedge clk);
        check("simul_pre_count", 64'(fifo_count), 64'(2));
        in_data  = 8'h78;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("simul_count",   64'(fifo_count), 64'(2));
        check("simul_restart", 64'(uart_tx),    64'(0));
        wait_idle(tend);
        repeat (5) @(negedge clk);

        // Reset during data bit 3 of the second of three queued frames.
        for (int i = 0; i < 3; i++) begin
            in_data  = (i == 0) ? 8'h81 : (i == 1) ? 8'h42 : 8'hC7;
            in_valid = 1'b1;
            @(negedge clk);
            if (i == 0) ca = cyc;
        end
        in_valid = 1'b0;
        while (cyc < ca + FL + 1 + 4 * D + 1) @(negedge clk);
        check("rst_mid_pre_count", 64'(fifo_count), 64'(1));
        check("rst_mid_pre_busy",  64'(busy),       64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_tx",    64'(uart_tx),    64'(1));
        check("rst_mid_count", 64'(fifo_count), 64'(0));
        check("rst_mid_busy",  64'(busy),       64'(0));
        check("rst_mid_ready", 64'(in_ready),   64'(1));
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        quiet = 0;
        repeat (3 * FL) begin
            @(negedge clk);
            if (busy || !uart_tx) quiet++;
        end
        check("rst_no_resume", 64'(quiet), 64'(0));

        // Randomized traffic with short gaps so the FIFO fills and pointers wrap.
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            push_one(8'($urandom));
        end
        wait_idle(tend);
        repeat (3) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_count", 64'(fifo_count),   64'(0));

        // Default parameters: 0x31 gives a 234-cycle start bit and 2340-cycle frame.
        def_byte   = 8'h31;
        sym_d      = {1'b1, def_byte, 1'b0};
        in_data_d  = def_byte;
        in_valid_d = 1'b1;
        @(negedge clk);
        in_valid_d = 1'b0;
        mism      = 0;
        start_len = 0;
        in_start  = 1'b1;
        for (int i = 0; i < 10 * DD; i++) begin
            @(negedge clk);
            if (uart_tx_d !== sym_d[i / DD] || !busy_d) mism++;
            if (in_start && uart_tx_d == 1'b0) start_len++;
            else in_start = 1'b0;
        end
        @(negedge clk);
        check("def_wave",  64'(mism),      64'(0));
        check("def_start", 64'(start_len), 64'(DD));
        check("def_end",   64'(busy_d),    64'(0));
        check("def_idle",  64'(uart_tx_d), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
